// File: rtl/multdiv_pkg.sv
// Shared definitions for the MultDiv unit: divider width, FSM encoding and
// iteration-counter sizing.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // The counter must be able to represent 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then try to
// subtract the divisor from the partial remainder and record the quotient bit.
module div_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    // Two extra bits over the shifted remainder: the top bit of the difference
    // is the borrow, so "no borrow" is the same as "shifted >= divisor".
    logic [WIDTH+1:0] diff;
    logic             fits;

    // Trial subtraction; keep the difference only if it did not go negative.
    always_comb begin
        diff    = {rem, quo[WIDTH-1]} - {2'b00, divisor};
        fits    = ~diff[WIDTH+1];
        rem_nxt = fits ? diff[WIDTH:0] : {rem[WIDTH-1:0], quo[WIDTH-1]};
        quo_nxt = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/udiv_iterative.sv
// Multicycle unsigned restoring divider, one quotient bit per clock.
// A start (ctrl_div) is honoured in every state and restarts the operation,
// so an in-flight divide is silently abandoned. Divide-by-zero skips the
// iterations and reports an exception one cycle later.
module udiv_iterative
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_dividend,
    input  logic [WIDTH-1:0] data_divisor,
    output logic [WIDTH-1:0] data_quotient,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_e       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem_q;    // one spare bit so the trial subtract cannot overflow
    logic [WIDTH-1:0] quo_q;    // dividend shifts out the top as quotient bits shift in
    logic [WIDTH-1:0] dvs_q;
    logic             zero_pend; // divide-by-zero waiting for its completion cycle

    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dvs_q),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            dvs_q          <= '0;
            zero_pend      <= 1'b0;
            data_quotient  <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else if (ctrl_div) begin
            // New operation from any state; an in-flight one is dropped.
            rem_q          <= '0;
            quo_q          <= data_dividend;
            dvs_q          <= data_divisor;
            cnt            <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
            if (data_divisor == '0) begin
                state     <= ST_DONE;
                zero_pend <= 1'b1;
            end else begin
                state     <= ST_RUN;
                zero_pend <= 1'b0;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state          <= ST_DONE;
                        data_quotient  <= quo_nxt;
                        data_remainder <= rem_nxt[WIDTH-1:0];
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (zero_pend) begin
                        // Divide-by-zero: publish the exception, stay one more
                        // cycle in DONE so the pulse is seen.
                        zero_pend      <= 1'b0;
                        data_quotient  <= '0;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                        busy           <= 1'b0;
                    end else begin
                        data_resultRDY <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    data_resultRDY <= 1'b0;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
